// File: rtl/arb_mux_pkg.sv
// Shared constants for the N-input registered arbiter/mux (arb_mux_n).
package arb_mux_pkg;

  localparam int MODE_FIXED  = 0;   // channel index comes from In_Sel
  localparam int MODE_RR     = 1;   // round-robin over In_Valid
  localparam int STALL_CNT_W = 16;  // width of the optional stall counter

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N_IN. Purely combinational, no state.
module rr_pick #(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int j;

  // Scan N_IN slots starting at ptr; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < N_IN; k++) begin
      j = (int'(ptr) + k) % N_IN;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input valid/ready mux with a single-entry output register.
// MODE 0 selects the channel named by In_Sel; MODE 1 arbitrates round-robin.
// Optional feature macro: ARB_MUX_STALL_CNT_EN adds the Stall_Cnt output,
// a saturating count of cycles spent with Out_Valid & !Out_Ready.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN),
  parameter int MODE  = MODE_FIXED
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_IN*WIDTH-1:0]   In_Data,
  input  logic [N_IN-1:0]         In_Valid,
  output logic [N_IN-1:0]         In_Ready,
  input  logic [SEL_W-1:0]        In_Sel,
  output logic [WIDTH-1:0]        Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
`ifdef ARB_MUX_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]  Stall_Cnt,
`endif
  output logic [SEL_W-1:0]        Out_Grant
);

  logic             any_eligible;
  logic [SEL_W-1:0] grant_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_vld_q,  out_vld_d;
  logic [SEL_W-1:0] out_gnt_q,  out_gnt_d;

  generate
    if (MODE == MODE_RR) begin : gen_rr
      logic [SEL_W-1:0] rr_ptr_q;
      logic             unused_sel;

      // In_Sel has no meaning in round-robin mode.
      assign unused_sel = ^In_Sel;

      rr_pick #(.N_IN(N_IN), .SEL_W(SEL_W)) u_pick (
        .req     (In_Valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (grant_idx),
        .gnt_any (any_eligible)
      );

      // Pointer moves past the winner only on an actual grant.
      always_ff @(posedge clk) begin
        if (!rstn)
          rr_ptr_q <= '0;
        else if (accept)
          rr_ptr_q <= SEL_W'(wrap_inc(int'(grant_idx), N_IN));
      end
    end else begin : gen_fix
      logic sel_vld;

      // Out-of-range In_Sel matches no channel and is never eligible.
      always_comb begin
        sel_vld = 1'b0;
        for (int i = 0; i < N_IN; i++)
          if (In_Sel == SEL_W'(i)) sel_vld = In_Valid[i];
      end

      assign grant_idx    = In_Sel;
      assign any_eligible = sel_vld;
    end
  endgenerate

  // Take a beat when the output slot is free or being drained this cycle.
  // Gating with rstn keeps In_Ready low during reset.
  assign accept = rstn & (~out_vld_q | Out_Ready) & any_eligible;

  // One-hot ready toward the granted channel; zero when nothing is accepted.
  always_comb begin
    In_Ready = '0;
    for (int i = 0; i < N_IN; i++)
      In_Ready[i] = accept && (grant_idx == SEL_W'(i));
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++)
      if (grant_idx == SEL_W'(i)) sel_data = In_Data[i*WIDTH +: WIDTH];
  end

  // Next state of the output register: fill, drain, or hold.
  always_comb begin
    out_data_d = out_data_q;
    out_gnt_d  = out_gnt_q;
    out_vld_d  = out_vld_q;
    if (accept) begin
      out_data_d = sel_data;
      out_gnt_d  = grant_idx;
      out_vld_d  = 1'b1;
    end else if (Out_Ready) begin
      out_vld_d  = 1'b0;
    end
  end

  // Output register; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data_q <= '0;
      out_gnt_q  <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_gnt_q  <= out_gnt_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Valid = out_vld_q;
  assign Out_Grant = out_gnt_q;

`ifdef ARB_MUX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles the consumer holds off a valid beat.
  always_ff @(posedge clk) begin
    if (!rstn)
      stall_cnt_q <= '0;
    else if (out_vld_q && !Out_Ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N-input, registered successor to the 2:1 datapath mux.
- Selects one of N valid/ready input channels and presents it through a single-entry output register.
- Two modes: fixed-select, where the index comes from In_Sel, and round-robin arbitration.
- Sits between multiple producers (e.g. writeback sources, memory response paths) and one consumer in the pipelined CPU.

Parameters:
- WIDTH, 32, data width per channel.
- N_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(N_IN), index width (derived; do not override).
- MODE, 0, 0 = fixed select via In_Sel; 1 = round-robin arbitration (In_Sel ignored).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous reset, active-low.
- In_Data  input  N_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- In_Valid  input  N_IN  per-channel valid.
- In_Ready  output  N_IN  per-channel ready; combinational.
- In_Sel  input  SEL_W  channel index, MODE 0 only.
- Out_Data  output  WIDTH  registered selected data.
- Out_Valid  output  1  registered valid.
- Out_Ready  input  1  consumer ready.
- Out_Grant  output  SEL_W  registered index of the channel held in the output register.

Behaviour:
- Reset: synchronous, active-low. Sampling rstn=0 at a clock edge clears Out_Data=0, Out_Valid=0, Out_Grant=0 and rr_ptr=0. Any held beat is discarded. In_Ready is 0 while rstn=0.
- Accept condition: accept = (!Out_Valid | Out_Ready) & any_eligible.
  - MODE 0: any_eligible = In_Valid[In_Sel].
  - MODE 1: any_eligible = |In_Valid.
- Grant selection:
  - MODE 0: g = In_Sel.
  - MODE 1: g = first i with In_Valid[i]=1, searching from rr_ptr upward and wrapping modulo N_IN.
- In_Ready[i] = accept & (i==g); at most one bit is set (one-hot or zero).
- Transfer: on an edge where accept=1, Out_Data <= In_Data[g], Out_Grant <= g, Out_Valid <= 1.
  - MODE 1 only: rr_ptr <= (g==N_IN-1) ? 0 : g+1.
- Drain: on an edge where Out_Valid & Out_Ready & !accept, Out_Valid <= 0. Out_Data and Out_Grant hold their last values.
- Stall: when Out_Valid & !Out_Ready, all outputs hold and In_Ready = 0.
- Simultaneous drain and fill: the output register is replaced in the same cycle, giving full throughput of 1 beat/cycle.
- Latency: 1 cycle from input handshake to Out_Valid.
- rr_ptr advances only on a grant. Idle cycles leave it unchanged.
- Fixed mode, In_Sel out of range (>= N_IN): treated as not eligible; no grant is made.
- In_Sel changing while the output is stalled has no effect on the held beat.
- Combinational paths: Out_Ready -> In_Ready and In_Valid -> In_Ready exist. No path exists from In_Data to any output.

Optional Feature:
- Macro: ARB_MUX_STALL_CNT_EN.
- Defined:
  - Adds output Stall_Cnt [15:0].
  - Increments each cycle Out_Valid & !Out_Ready and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package arb_mux_pkg:
  - MODE_FIXED=0, MODE_RR=1 localparams.
  - Stall counter width constant STALL_CNT_W=16.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[N_IN], ptr[SEL_W]. Outputs: gnt_idx[SEL_W], gnt_any.
  - Instantiated only when MODE=1.

Test Plan:
- Reset mid-stream: hold Out_Ready=0 with a beat held (Out_Valid=1), assert rstn=0 for 1 cycle -> next cycle Out_Valid=0, Out_Grant=0, Out_Data=0. Afterwards, with all In_Valid=1, the first grant is channel 0.
- MODE 0, N_IN=4: In_Sel=2, In_Valid=4'b0100, Data2=32'hDEADBEEF, Out_Ready=1 -> In_Ready=4'b0100, and the next cycle Out_Data=32'hDEADBEEF, Out_Grant=2. In_Sel=5 with N_IN=4 (SEL_W=3 test build) -> no grant.
- MODE 1 fairness: In_Valid=4'b1111 held, Out_Ready=1 for 8 cycles -> Out_Grant sequence 0,1,2,3,0,1,2,3 with Out_Valid continuously 1.
- MODE 1 wrap/skip: rr_ptr=3 after granting 2, In_Valid=4'b0011 -> grant 0, then 1. Then In_Valid=4'b1000 -> grant 3.
- Backpressure: Out_Valid=1, Out_Ready=0 for 3 cycles with inputs valid -> In_Ready=0 and outputs stable. Then Out_Ready=1 -> drain and refill in the same cycle. With ARB_MUX_STALL_CNT_EN defined, Stall_Cnt=3.
